// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// FSM state encoding, nibble width and counter sizing helper.
package nibble_add_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the nibble counter for a given operand width; never below 1 bit.
  function automatic int cnt_width(input int width);
    int n;
    n = width / NIB_W;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fulladder.sv
// 4-bit ripple-carry adder built from a chain of single-bit full adders.
module fulladder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_add_seq.sv
// Multi-precision add/subtract over WIDTH/4 cycles through one shared 4-bit adder,
// least significant nibble first, with the carry registered between nibbles.
module nibble_add_seq
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_t           state_dbg
);

  localparam int N     = WIDTH / NIB_W;
  localparam int CNT_W = cnt_width(WIDTH);
  localparam int SR_W  = WIDTH - NIB_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  if ((WIDTH % NIB_W != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("nibble_add_seq: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic               carry_q, carry_d;
  logic               a_msb_q, a_msb_d;
  logic               b_msb_q, b_msb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [NIB_W-1:0]   add_s;
  logic               add_co;
  logic [WIDTH-1:0]   sum_w;
  logic [WIDTH-1:0]   b_eff;
  logic               accept;

  fulladder u_fulladder (
    .a    (a_sr_q[NIB_W-1:0]),
    .b    (b_sr_q[NIB_W-1:0]),
    .cin  (carry_q),
    .s    (add_s),
    .cout (add_co)
  );

  // Handshake: start is a request that is taken on any rising edge where
  // busy=0 (IDLE or DONE). ~busy is the only ready; requests made while
  // busy=1 are dropped, and operands/cin/sub are only sampled with the
  // accepted start.
  assign accept = start && (state_q != ST_RUN);
  assign b_eff  = sub ? ~b : b;

  // Previously produced nibbles sit in sr_q; the adder output completes the word.
  assign sum_w  = {add_s, sr_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sr_d    = sr_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_RUN: begin
        a_sr_d  = a_sr_q >> NIB_W;
        b_sr_d  = b_sr_q >> NIB_W;
        sr_d    = sum_w[WIDTH-1:NIB_W];
        carry_d = add_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          sum_d   = sum_w;
          cout_d  = add_co;
          ovf_d   = (a_msb_q == b_msb_q) && (add_s[NIB_W-1] != a_msb_q);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new operation may start from IDLE or straight out of DONE.
    if (accept) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      a_sr_d  = a;
      b_sr_d  = b_eff;
      carry_d = sub ? 1'b1 : cin;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b_eff[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sr_q    <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sr_q    <= sr_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule
